tempest_spinner: RTL and testbench
==================================

# tempest_spinner

Converts MiSTer digital joystick left/right or the absolute paddle position into the 4-bit relative spinner count read by the Tempest game core. Sits between hps_io joystick/paddle outputs and the `buttons` input of the core top, in the 50 MHz core clock domain. Inputs are resynchronised from the hps_io domain. Digital mode applies hold-time acceleration.

## Interface
- CLK_HZ, 50000000, core clock frequency.
- STEP_HZ, 1000, spinner update tick rate.
- ACCEL_MAX, 4, maximum counts per tick in digital mode (1..7).
- HOLD_TICKS, 32, ticks of continuous hold per acceleration step.

Ports:
- clk_i  in  1  core clock, single clock domain.
- btnCpuReset  in  1  asynchronous, active-low reset.
- joy_left  in  1  digital left (async to clk_i).
- joy_right  in  1  digital right (async to clk_i).
- use_paddle  in  1  1 = paddle mode, 0 = digital mode (async).
- paddle_i  in  8  absolute paddle position, unsigned 0..255 (async bus).
- pos_o  out  4  spinner count, wraps mod 16.
- dir_o  out  1  last movement direction: 1 = right/increment, 0 = left/decrement.
- tick_o  out  1  one-cycle pulse on each update tick (debug/bench).

## Operation
- joy_left, joy_right, use_paddle: 2-flop synchronisers.
- paddle_i: registered every cycle. A sample is accepted only when two consecutive registered values are equal; otherwise the previous accepted value is held.
- Tick divider counts 0..(CLK_HZ/STEP_HZ − 1). tick_o pulses when the counter wraps.
- Digital mode, evaluated on each tick:
  - Exactly one of left/right held: pos_o += step (right) or −= step (left), mod 16. dir_o is set to match.
  - hold_cnt increments. On reaching HOLD_TICKS−1, it clears and step increments, saturating at ACCEL_MAX.
  - Neither or both held: no movement, step = 1, hold_cnt = 0, dir_o unchanged.
  - Direction differs from dir_o while held: the move still happens, but uses step = 1, and step and hold_cnt reset first.
- Paddle mode, evaluated on each tick:
  - delta = accepted − paddle_last, as a signed 9-bit value.
  - d = clamp(delta, −7, +7).
  - pos_o += d (mod 16) and paddle_last += d, so the remainder carries to later ticks.
  - dir_o is set only when d ≠ 0.
  - No acceleration: step and hold_cnt are held at reset values.
- Paddle seeding: the first tick after reset, or after use_paddle rises, loads paddle_last with the accepted value and produces no movement.
- A change of use_paddle takes effect at the next tick after synchronisation. A mid-move switch discards no pos_o state.

## Timing
- Reset values: pos_o = 0, dir_o = 0, tick_o = 0, step = 1, hold_cnt = 0, paddle_last = 0, seed flag = 1, divider = 0.
- Latency from input pin to visible movement:
  - 2 synchroniser cycles, plus up to one tick period.
  - pos_o registers in the cycle after tick_o is high, so it is visible 1 cycle after the tick.
  - The paddle path adds 2 cycles for stability qualification.
- pos_o changes at most once per tick period and is otherwise stable. The core may sample it at any time.
- Reset deassertion mid-hold: behaves as a fresh press. The first tick moves by 1.
- Wrap: 15 + 1 → 0; 0 − 1 → 15; 14 + 4 → 2.

## Configuration
- SPINNER_ACCEL_EN defined: digital-mode acceleration as described.
- SPINNER_ACCEL_EN undefined:
  - step is constant 1.
  - hold_cnt and the acceleration logic are removed.
  - ACCEL_MAX and HOLD_TICKS are ignored.
  - Paddle mode is unchanged.

## Test plan
Bench parameters: CLK_HZ=1000, STEP_HZ=100 (tick every 10 cycles), HOLD_TICKS=4, ACCEL_MAX=3.

- Reset, then idle 100 cycles -> pos_o = 0, dir_o = 0, tick_o pulses every 10 cycles.
- Hold joy_right 12 ticks (macro defined) -> increments 1,1,1,1,2,2,2,2,3,3,3,3. pos_o = 24 mod 16 = 8, dir_o = 1. Without the macro, pos_o = 12.
- Hold right 3 ticks, then switch to left for 1 tick -> pos_o = 3 then 2, dir_o = 0, step back to 1.
- Hold left and right together 5 ticks starting from pos_o = 5 -> pos_o stays 5, step = 1.
- use_paddle = 1 with paddle_i = 100 -> first tick, no move. Then set paddle_i = 120 -> successive ticks +7, +7, +6, and pos_o advances by 20 mod 16 = 4. Then paddle_i = 95 -> −7, −7, −7, −4.
- paddle_i toggling every cycle between 10 and 200 -> accepted value is never updated and pos_o does not change.

Source files
------------

// File: rtl/tempest_spinner.sv
// Joystick left/right or absolute paddle to the 4-bit relative spinner count of the Tempest core.
// Define SPINNER_ACCEL_EN to enable hold-time acceleration in digital mode.
module tempest_spinner #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned STEP_HZ    = 1000,
  parameter int unsigned ACCEL_MAX  = 4,
  parameter int unsigned HOLD_TICKS = 32
) (
  input  logic       clk_i,
  input  logic       btnCpuReset,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic       use_paddle,
  input  logic [7:0] paddle_i,
  output logic [3:0] pos_o,
  output logic       dir_o,
  output logic       tick_o
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tempest_spinner: CLK_HZ/STEP_HZ must be at least 2");
  end
  if (ACCEL_MAX < 1 || ACCEL_MAX > 7) begin : g_bad_accel
    $error("tempest_spinner: ACCEL_MAX must be 1..7");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("tempest_spinner: HOLD_TICKS must be at least 1");
  end

  logic [1:0] left_sync, right_sync, mode_sync;
  logic       mode_prev;
  logic       left_s, right_s, paddle_mode, mode_rise;

  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      left_sync  <= '0;
      right_sync <= '0;
      mode_sync  <= '0;
      mode_prev  <= 1'b0;
    end else begin
      left_sync  <= {left_sync[0], joy_left};
      right_sync <= {right_sync[0], joy_right};
      mode_sync  <= {mode_sync[0], use_paddle};
      mode_prev  <= mode_sync[1];
    end
  end

  assign left_s      = left_sync[1];
  assign right_s     = right_sync[1];
  assign paddle_mode = mode_sync[1];
  assign mode_rise   = mode_sync[1] & ~mode_prev;

  // A paddle sample is only trusted once two consecutive registered copies agree.
  logic [7:0] pad_r1, pad_r2, pad_acc;

  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      pad_r1  <= '0;
      pad_r2  <= '0;
      pad_acc <= '0;
    end else begin
      pad_r1 <= paddle_i;
      pad_r2 <= pad_r1;
      if (pad_r1 == pad_r2) pad_acc <= pad_r2;
    end
  end

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      div_cnt <= '0;
      tick_o  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick_o  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      tick_o  <= 1'b0;
    end
  end

`ifdef SPINNER_ACCEL_EN
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [2:0]    STEP_MAX  = 3'(ACCEL_MAX);
  logic [2:0]    step_q, step_n, step_cur;
  logic [HW-1:0] hold_q, hold_n, hold_cur;
`endif

  logic [3:0]        pos_n, d, mv;
  logic              dir_n, seed_q, seed_n;
  logic [7:0]        last_q, last_n;
  logic signed [8:0] delta;

  always_comb begin
    pos_n  = pos_o;
    dir_n  = dir_o;
    last_n = last_q;
    seed_n = seed_q | mode_rise;
    mv     = 4'd1;
    delta  = $signed({1'b0, pad_acc}) - $signed({1'b0, last_q});
    if (delta > 9'sd7)       d = 4'd7;
    else if (delta < -9'sd7) d = 4'b1001;
    else                     d = delta[3:0];
`ifdef SPINNER_ACCEL_EN
    step_n   = step_q;
    hold_n   = hold_q;
    step_cur = step_q;
    hold_cur = hold_q;
`endif
    if (tick_o) begin
      if (paddle_mode) begin
`ifdef SPINNER_ACCEL_EN
        step_n = 3'd1;
        hold_n = '0;
`endif
        if (seed_n) begin
          last_n = pad_acc;
          seed_n = 1'b0;
        end else begin
          // Only the clamped part is consumed; the rest of the delta carries to later ticks.
          pos_n  = pos_o + d;
          last_n = last_q + {{4{d[3]}}, d};
          if (d != 4'd0) dir_n = ~d[3];
        end
      end else if (left_s ^ right_s) begin
        dir_n = right_s;
`ifdef SPINNER_ACCEL_EN
        if (right_s != dir_o) begin
          step_cur = 3'd1;
          hold_cur = '0;
        end
        mv = {1'b0, step_cur};
        if (hold_cur == HOLD_LAST) begin
          hold_n = '0;
          step_n = (step_cur < STEP_MAX) ? step_cur + 3'd1 : step_cur;
        end else begin
          hold_n = hold_cur + HW'(1);
          step_n = step_cur;
        end
`endif
        pos_n = right_s ? pos_o + mv : pos_o - mv;
      end else begin
`ifdef SPINNER_ACCEL_EN
        step_n = 3'd1;
        hold_n = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      pos_o  <= '0;
      dir_o  <= 1'b0;
      last_q <= '0;
      seed_q <= 1'b1;
`ifdef SPINNER_ACCEL_EN
      step_q <= 3'd1;
      hold_q <= '0;
`endif
    end else begin
      pos_o  <= pos_n;
      dir_o  <= dir_n;
      last_q <= last_n;
      seed_q <= seed_n;
`ifdef SPINNER_ACCEL_EN
      step_q <= step_n;
      hold_q <= hold_n;
`endif
    end
  end

endmodule

// File: tb/tb_tempest_spinner.sv
// Bench for tempest_spinner: per-cycle comparison against a tick-level behavioural model plus literal checkpoints.
module tb_tempest_spinner;

  localparam int HOLD = 4;
  localparam int AMAX = 3;
`ifdef SPINNER_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       joy_left = 1'b0, joy_right = 1'b0, use_paddle = 1'b0;
  logic [7:0] paddle_i = 8'd0;
  logic [3:0] pos_o;
  logic       dir_o, tick_o;

  int checks = 0;
  int errors = 0;

  tempest_spinner #(
    .CLK_HZ(1000), .STEP_HZ(100), .ACCEL_MAX(AMAX), .HOLD_TICKS(HOLD)
  ) dut (
    .clk_i(clk), .btnCpuReset(rst_n), .joy_left(joy_left), .joy_right(joy_right),
    .use_paddle(use_paddle), .paddle_i(paddle_i), .pos_o(pos_o), .dir_o(dir_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen two edges late, ticks every 10 edges, movement applied at the edge after a tick.
  int m = 0, run = 0, m_pos = 0, m_last = 0, m_acc = 0;
  bit m_dir = 1'b0, m_seed = 1'b1, m_tick = 1'b0;
  bit lh[4], rh[4], uh[4];
  int ph[4];

  task automatic model_tick();
    int d, step;
    if (uh[2]) begin
      run = 0;
      if (m_seed) begin
        m_last = m_acc;
        m_seed = 1'b0;
      end else begin
        d = m_acc - m_last;
        if (d > 7) d = 7;
        if (d < -7) d = -7;
        m_pos  = (m_pos + d + 16) % 16;
        m_last = (m_last + d + 256) % 256;
        if (d != 0) m_dir = (d > 0);
      end
    end else if (lh[2] != rh[2]) begin
      if (rh[2] != m_dir) run = 0;
      step = ACCEL ? 1 + run / HOLD : 1;
      if (step > AMAX) step = AMAX;
      m_pos = rh[2] ? (m_pos + step) % 16 : (m_pos - step + 16) % 16;
      m_dir = rh[2];
      run++;
    end else begin
      run = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = 0; run = 0; m_pos = 0; m_last = 0; m_acc = 0;
      m_dir = 1'b0; m_seed = 1'b1; m_tick = 1'b0;
      for (int i = 0; i < 4; i++) begin
        lh[i] = 1'b0; rh[i] = 1'b0; uh[i] = 1'b0; ph[i] = 0;
      end
    end else begin
      m++;
      for (int i = 3; i > 0; i--) begin
        lh[i] = lh[i-1]; rh[i] = rh[i-1]; uh[i] = uh[i-1]; ph[i] = ph[i-1];
      end
      lh[0] = joy_left; rh[0] = joy_right; uh[0] = use_paddle; ph[0] = int'(paddle_i);
      if (uh[2] && !uh[3]) m_seed = 1'b1;
      if (m >= 11 && m % 10 == 1) model_tick();
      if (ph[1] == ph[2]) m_acc = ph[2];
      m_tick = (m % 10 == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && m >= 1) begin
      check("pos", int'(pos_o), m_pos);
      check("dir", int'(dir_o), int'(m_dir));
      check("tick", int'(tick_o), int'(m_tick));
    end
  end

  task automatic lit(input string name, input int exp);
    check({name, " dut"}, int'(pos_o), exp);
    check({name, " model"}, m_pos, exp);
  endtask

  task automatic ticks(input int n);
    repeat (10 * n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pos", int'(pos_o), 0);
    check("reset_dir", int'(dir_o), 0);
    check("reset_tick", int'(tick_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    @(negedge clk);
    do_reset();

    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick_o) pulses++;
    end
    check("idle_tick_count", pulses, 10);
    lit("idle_pos", 0);
    check("idle_dir", int'(dir_o), 0);

    joy_right = 1'b1;
    ticks(4);  lit("hold4", 4);
    ticks(4);  lit("hold8", ACCEL ? 12 : 8);
    ticks(4);  lit("hold12", ACCEL ? 8 : 12);
    check("hold12_dir", int'(dir_o), 1);

    do_reset();
    ticks(3);  lit("fresh3", 3);
    joy_right = 1'b0; joy_left = 1'b1;
    ticks(1);  lit("switch_left", 2);
    check("switch_dir", int'(dir_o), 0);
    joy_left = 1'b0; joy_right = 1'b1;
    ticks(8);  lit("right8", ACCEL ? 14 : 10);
    joy_right = 1'b0; joy_left = 1'b1;
    ticks(1);  lit("reverse_step1", ACCEL ? 13 : 9);

    joy_left = 1'b0; joy_right = 1'b1;
    do_reset();
    ticks(4);  lit("pre_both4", 4);
    joy_right = 1'b0;
    ticks(1);  lit("neither", 4);
    joy_right = 1'b1;
    ticks(1);  lit("pos5", 5);
    joy_left = 1'b1;
    ticks(5);  lit("both5", 5);
    check("both_dir", int'(dir_o), 1);
    joy_left = 1'b0;
    ticks(1);  lit("after_both", 6);

    joy_right = 1'b0;
    do_reset();
    joy_left = 1'b1;
    ticks(1);  lit("wrap_down", 15);
    joy_left = 1'b0; joy_right = 1'b1;
    ticks(1);  lit("wrap_up", 0);
    joy_right = 1'b0;

    use_paddle = 1'b1; paddle_i = 8'd100;
    ticks(1);  lit("paddle_seed", 0);
    paddle_i = 8'd120;
    ticks(1);  lit("pad_up1", 7);
    ticks(1);  lit("pad_up2", 14);
    ticks(1);  lit("pad_up3", 4);
    check("pad_up_dir", int'(dir_o), 1);
    ticks(1);  lit("pad_settled", 4);
    paddle_i = 8'd95;
    ticks(1);  lit("pad_dn1", 13);
    ticks(1);  lit("pad_dn2", 6);
    ticks(1);  lit("pad_dn3", 15);
    ticks(1);  lit("pad_dn4", 11);
    check("pad_dn_dir", int'(dir_o), 0);

    for (int i = 0; i < 30; i++) begin
      paddle_i = i[0] ? 8'd200 : 8'd10;
      @(negedge clk);
    end
    lit("pad_toggle", 11);
    paddle_i = 8'd95;
    ticks(1);  lit("pad_toggle_after", 11);

    use_paddle = 1'b0; joy_right = 1'b1;
    ticks(1);  lit("to_digital", 12);
    joy_right = 1'b0; use_paddle = 1'b1; paddle_i = 8'd100;
    ticks(1);  lit("reseed", 12);
    paddle_i = 8'd105;
    ticks(1);  lit("reseed_move", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
